// File: rtl/onchip_sram_pkg.sv
// Shared types and constants for the asymmetric dual-port SRAM.
// Optional collision counter: ONCHIP_SRAM_COLLISION_CNT_EN.
package onchip_sram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int COLL_CNT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/onchip_sram_rd_pipe.sv
// Read-latency pipeline: valid shift register plus held output data.
// Optional collision counter in top: ONCHIP_SRAM_COLLISION_CNT_EN.
module onchip_sram_rd_pipe
  import onchip_sram_pkg::*;
#(
  parameter int W       = 64,
  parameter int LATENCY = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int L = (LATENCY > RD_LAT_MAX) ? RD_LAT_MAX :
                     (LATENCY < RD_LAT_MIN) ? RD_LAT_MIN : LATENCY;

  logic [L-1:0] v_q;
  logic [W-1:0] d_q [L];

  // Stages only load on a valid beat so the output holds between pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < L; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= valid_i;
      if (valid_i) d_q[0] <= data_i;
      for (int i = 1; i < L; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign valid_o = v_q[L-1];
  assign data_o  = d_q[L-1];

endmodule

// File: rtl/onchip_sram_asym_dp.sv
// True dual-port SRAM, wide port A / narrow port B, Avalon-MM slaves.
// Optional saturating collision counter: ONCHIP_SRAM_COLLISION_CNT_EN.
module onchip_sram_asym_dp
  import onchip_sram_pkg::*;
#(
  parameter int DATA_W_B       = 64,
  parameter int RATIO          = 4,
  parameter int ADDR_W_B       = 6,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int DATA_W_A      = DATA_W_B * RATIO,
  localparam int ADDR_W_A      = ADDR_W_B - clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W_A-1:0]   a_address,
  input  logic                  a_chipselect,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_W_A/8-1:0] a_byteenable,
  input  logic [DATA_W_A-1:0]   a_writedata,
  output logic [DATA_W_A-1:0]   a_readdata,
  output logic                  a_readdatavalid,
  output logic                  a_waitrequest,
  input  logic [ADDR_W_B-1:0]   b_address,
  input  logic                  b_chipselect,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_W_B/8-1:0] b_byteenable,
  input  logic [DATA_W_B-1:0]   b_writedata,
  output logic [DATA_W_B-1:0]   b_readdata,
  output logic                  b_readdatavalid,
  output logic                  b_waitrequest,
`ifdef ONCHIP_SRAM_COLLISION_CNT_EN
  output logic [COLL_CNT_W-1:0] collision_count,
  input  logic                  collision_clr,
`endif
  output logic                  init_done
);

  localparam int LG    = clog2(RATIO);
  localparam int DEPTH = 1 << ADDR_W_B;
  localparam int NB    = DATA_W_B / 8;

  state_e              state_q, state_d;
  logic [ADDR_W_B-1:0] clr_cnt_q, clr_cnt_d;
  logic                clr_we;
  logic                busy;

  logic                a_acc, a_we, a_re;
  logic                b_acc, b_we, b_re;
  logic [ADDR_W_B-1:0] a_base;
  logic [DATA_W_A-1:0] a_rdata;
  logic [DATA_W_B-1:0] b_rdata;

  logic [DATA_W_B-1:0] mem_q [DEPTH];

  assign busy          = (state_q != ST_READY);
  assign a_waitrequest = busy;
  assign b_waitrequest = busy;
  assign init_done     = ~busy;

  // A write with read also raised is a plain write
  assign a_acc = a_chipselect & (a_read | a_write) & ~busy;
  assign a_we  = a_acc & a_write;
  assign a_re  = a_acc & ~a_write;
  assign b_acc = b_chipselect & (b_read | b_write) & ~busy;
  assign b_we  = b_acc & b_write;
  assign b_re  = b_acc & ~b_write;

  assign a_base = ADDR_W_B'(a_address) << LG;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_d = ST_READY;
        end else begin
          clr_we    = 1'b1;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (&clr_cnt_q) state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Port A is written last so it wins any byte both ports hit
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_cnt_q] <= '0;
    if (b_we)
      for (int j = 0; j < NB; j++)
        if (b_byteenable[j])
          mem_q[b_address][j*8 +: 8] <= b_writedata[j*8 +: 8];
    if (a_we)
      for (int k = 0; k < RATIO; k++)
        for (int j = 0; j < NB; j++)
          if (a_byteenable[k*NB + j])
            mem_q[a_base | ADDR_W_B'(k)][j*8 +: 8] <=
              a_writedata[(k*NB + j)*8 +: 8];
  end

  always_comb begin
    a_rdata = '0;
    for (int k = 0; k < RATIO; k++)
      a_rdata[k*DATA_W_B +: DATA_W_B] = mem_q[a_base | ADDR_W_B'(k)];
  end

  assign b_rdata = mem_q[b_address];

  onchip_sram_rd_pipe #(
    .W       (DATA_W_A),
    .LATENCY (READ_LATENCY)
  ) u_pipe_a (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (a_re),
    .data_i  (a_rdata),
    .valid_o (a_readdatavalid),
    .data_o  (a_readdata)
  );

  onchip_sram_rd_pipe #(
    .W       (DATA_W_B),
    .LATENCY (READ_LATENCY)
  ) u_pipe_b (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (b_re),
    .data_i  (b_rdata),
    .valid_o (b_readdatavalid),
    .data_o  (b_readdata)
  );

`ifdef ONCHIP_SRAM_COLLISION_CNT_EN
  logic                  coll_hit;
  logic [COLL_CNT_W-1:0] coll_q, coll_d;

  always_comb begin
    coll_hit = 1'b0;
    for (int k = 0; k < RATIO; k++)
      if (a_we && b_we && ((a_base | ADDR_W_B'(k)) == b_address) &&
          |(a_byteenable[k*NB +: NB] & b_byteenable))
        coll_hit = 1'b1;
    coll_d = coll_q;
    if (collision_clr)              coll_d = '0;
    else if (coll_hit && ~&coll_q)  coll_d = coll_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) coll_q <= '0;
    else          coll_q <= coll_d;
  end

  assign collision_count = coll_q;
`endif

endmodule

// File: doc/onchip_sram_asym_dp.md
Name: onchip_sram_asym_dp

Overview:
Parametrised single-clock true-dual-port on-chip SRAM with asymmetric port widths. Port A is wide and port B is narrow; each is an Avalon-MM slave.
- Byte enables are honoured on both ports.
- Read latency is configurable and flagged by readdatavalid.
- Same-cycle write collisions are resolved per byte.
- An optional zero-clear sequencer runs after reset.
- Sits between wide DMA/accelerator masters (port A) and the processor-side bus (port B).

Parameters:
- DATA_W_B, 64: port B data width in bits; multiple of 8.
- RATIO, 4: width ratio A:B; power of 2, 1..8. Port A data width DATA_W_A = DATA_W_B*RATIO (derived localparam).
- ADDR_W_B, 6: port B address width. Depth is 2^ADDR_W_B narrow words.
- ADDR_W_A: derived localparam, ADDR_W_B - log2(RATIO).
- READ_LATENCY, 1: read latency in cycles, 1 or 2.
- CLEAR_ON_RESET, 1: when 1, zero the whole array after reset.

Ports:
- clk  in  1  single clock, both ports.
- reset_n  in  1  synchronous, active-low reset.
- a_address  in  ADDR_W_A  wide-word address.
- a_chipselect, a_read, a_write  in  1 each  port A controls.
- a_byteenable  in  DATA_W_A/8  per-byte write enable.
- a_writedata  in  DATA_W_A  write data.
- a_readdata  out  DATA_W_A  read data.
- a_readdatavalid  out  1  one-cycle pulse qualifying a_readdata.
- a_waitrequest  out  1  high while not ready.
- b_address  in  ADDR_W_B  narrow-word address.
- b_chipselect, b_read, b_write  in  1 each  port B controls.
- b_byteenable  in  DATA_W_B/8  per-byte write enable.
- b_writedata  in  DATA_W_B  write data.
- b_readdata  out  DATA_W_B  read data.
- b_readdatavalid  out  1  one-cycle pulse qualifying b_readdata.
- b_waitrequest  out  1  high while not ready.
- init_done  out  1  high once the array is usable.

Behaviour:
- Reset (reset_n sampled low at a clk edge):
  - readdata = 0, readdatavalid = 0, waitrequest = 1, init_done = 0.
  - Read pipelines are flushed; in-flight reads are dropped with no valid pulse.
- Lane mapping: wide word i, lane k (bits k*DATA_W_B +: DATA_W_B) is narrow word i*RATIO+k, little-endian.
- FSM states are ST_CLEAR and ST_READY.
  - After reset deassertion: ST_CLEAR if CLEAR_ON_RESET=1, else ST_READY.
  - ST_CLEAR writes all-zero to narrow word clr_cnt each cycle; clr_cnt counts 0..2^ADDR_W_B-1.
  - After the last word, go to ST_READY. waitrequest drops and init_done rises on the same edge.
  - Clear takes exactly 2^ADDR_W_B cycles; 64 at defaults.
  - reset_n low mid-clear restarts the clear at word 0.
- waitrequest is 1 on both ports in reset and ST_CLEAR, and 0 in ST_READY. No other stall source exists.
- A transfer is accepted when chipselect & (read|write) & !waitrequest.
- Write: bytes with byteenable=1 update at the accepting edge.
- Read:
  - readdata is driven and readdatavalid pulses exactly READ_LATENCY cycles after acceptance.
  - Back-to-back reads are fully pipelined: one per cycle.
  - readdata holds its last value when readdatavalid=0.
- read and write both asserted on one port: treated as a write only, with no valid pulse.
- Read-during-write returns OLD data, both on the same port and across ports.
- Same-cycle writes from both ports to the same byte: port A's byte wins. Non-overlapping bytes from both ports are all written.

Optional Feature:
- Macro: ONCHIP_SRAM_COLLISION_CNT_EN.
- When defined, adds two ports:
  - collision_count, out, 16: saturating count of accepted cycles in which both ports wrote at least one common byte. Reset value 0; holds at 16'hFFFF.
  - collision_clr, in, 1: zeroes the count next cycle. It takes priority over an increment in the same cycle.
- When undefined: ports and logic are absent. Collision resolution is unchanged.

Decomposition:
- Package onchip_sram_pkg:
  - state enum {ST_CLEAR, ST_READY};
  - clog2 constant function;
  - legal READ_LATENCY range;
  - collision counter width (16).
- Sub-module onchip_sram_rd_pipe (params W, LATENCY): readdatavalid shift register plus output data register. Instantiated once per port.

Test Plan:
- Clear timing and result: release reset_n with defaults -> waitrequest high exactly 64 cycles, then init_done=1; b read addr 63 -> 64'h0.
- Wide write, narrow read: A write addr 2, data {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, be all-1 -> B reads addr 8,9,10,11 return lanes 0..3 in order, each with readdatavalid 1 cycle after acceptance.
- Narrow partial write, wide read: after clear, B write addr 5, data 64'h1122334455667788, be 8'h0F -> A read addr 1 returns lane1 = 64'h0000000055667788, other lanes 0.
- Byte collision: A write addr 0, lane0 64'hAAAAAAAA_AAAAAAAA, be[7:0]=8'hF0 (rest 0), same cycle as B write addr 0, 64'h55555555_55555555, be 8'hFF -> narrow word 0 = 64'hAAAAAAAA_55555555; collision_count=1 with the macro defined.
- Read-during-write: A read addr 3 while B writes 64'h1 to addr 12 (old value 0) -> A lane0 = 0; next A read of addr 3 returns lane0 = 64'h1.
- Latency and reset restart:
  - READ_LATENCY=2: B reads 0,1,2 accepted on t, t+1, t+2 -> readdatavalid high on t+2..t+4.
  - reset_n low one cycle at clear cycle 30 -> waitrequest stays high for a full 64 further cycles.
